// File: rtl/rv32_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads on a valid/ready bus,
// applies static branch prediction and feeds the fetch/decode pipeline register.
module rv32_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        instr_read_out,
    output logic [31:0] instr_address_out,
    input  logic        instr_ready_in,
    input  logic [31:0] instr_read_value_in,
    output logic        branch_predicted_taken_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    typedef enum logic [1:0] {
        FETCH,
        DISCARD,
        HOLD
    } state_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OP_JAL     = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_pred;

    logic [31:0] word;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_back_branch;
    logic        pred_taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] redirect_pc;

    logic        load_valid;
    logic [31:0] load_instr;
    logic [31:0] load_pc;
    logic        load_pred;

    // Request and address depend only on registers, never on bus inputs.
    assign instr_read_out    = (state != HOLD);
    assign instr_address_out = pc;

    assign word        = instr_read_value_in;
    assign redirect_pc = redirect_pc_in & ALIGN_MASK;

    assign j_imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};

    // Backward conditional branches and all JALs are predicted taken.
    assign is_jal         = (word[6:0] == OP_JAL);
    assign is_back_branch = (word[6:0] == OP_BRANCH) && word[31];
    assign pred_taken     = is_jal || is_back_branch;

    always_comb begin
        target = pc + 32'd4;
        if (is_jal) begin
            target = pc + j_imm;
        end else if (is_back_branch) begin
            target = pc + b_imm;
        end
    end

    assign next_pc = target & ALIGN_MASK;

    // What the pipeline register would take this cycle absent stall/flush/redirect.
    always_comb begin
        load_valid = 1'b0;
        load_instr = word;
        load_pc    = pc;
        load_pred  = pred_taken;
        case (state)
            FETCH: begin
                load_valid = instr_ready_in;
            end
            HOLD: begin
                load_valid = 1'b1;
                load_instr = hold_instr;
                load_pc    = hold_pc;
                load_pred  = hold_pred;
            end
            default: begin
                load_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= FETCH;
            pc                         <= RESET_VECTOR;
            pending_pc                 <= 32'h0;
            hold_instr                 <= 32'h0;
            hold_pc                    <= 32'h0;
            hold_pred                  <= 1'b0;
            pc_out                     <= 32'h0;
            instr_out                  <= NOP;
            branch_predicted_taken_out <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_ready_in) begin
                        if (redirect_in) begin
                            pc <= redirect_pc;
                        end else if (stall_in) begin
                            hold_instr <= word;
                            hold_pc    <= pc;
                            hold_pred  <= pred_taken;
                            pc         <= next_pc;
                            state      <= HOLD;
                        end else begin
                            pc <= next_pc;
                        end
                    end else if (redirect_in) begin
                        // The read at pc is still in flight; keep its address stable.
                        pending_pc <= redirect_pc;
                        state      <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (redirect_in) begin
                        pending_pc <= redirect_pc;
                    end
                    if (instr_ready_in) begin
                        pc    <= redirect_in ? redirect_pc : pending_pc;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect_in) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!stall_in) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase

            if (!stall_in) begin
                if (flush_in || redirect_in || !load_valid) begin
                    instr_out                  <= NOP;
                    branch_predicted_taken_out <= 1'b0;
                end else begin
                    instr_out                  <= load_instr;
                    pc_out                     <= load_pc;
                    branch_predicted_taken_out <= load_pred;
                end
            end
        end
    end

endmodule
